// File: rtl/idu_pkg.sv
// Shared types for the IDU decode stage: opcodes, op classes, immediate formats,
// the decoded-bundle struct and the opcode classifier.
package idu_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OPIMM   = 4'd7,
    CLS_OP      = 4'd8,
    CLS_SYSTEM  = 4'd9,
    CLS_MISCMEM = 4'd10,
    CLS_ILLEGAL = 4'd11
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    op_class_e cls;
    imm_type_e imm_type;
    logic      use_rs1;
    logic      use_rs2;
    logic      use_rd;
  } op_info_t;

  // Register fields are kept at full 5-bit width; truncation to RA_W happens at the outputs.
  typedef struct packed {
    op_class_e   cls;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        illegal;
  } bundle_t;

  localparam bundle_t BUNDLE_RST = '{
    cls: CLS_ILLEGAL, funct3: 3'd0, funct7b5: 1'b0, rs1: 5'd0, rs2: 5'd0,
    rd: 5'd0, rd_wen: 1'b0, illegal: 1'b0
  };

  function automatic op_info_t mk_info(input op_class_e cls, input imm_type_e imm_type,
                                       input logic use_rs1, input logic use_rs2,
                                       input logic use_rd);
    op_info_t info;
    info.cls      = cls;
    info.imm_type = imm_type;
    info.use_rs1  = use_rs1;
    info.use_rs2  = use_rs2;
    info.use_rd   = use_rd;
    return info;
  endfunction

  function automatic op_info_t decode_opcode(input logic [6:0] opc);
    op_info_t info;
    info = mk_info(CLS_ILLEGAL, IMM_NONE, 1'b0, 1'b0, 1'b0);
    case (opc)
      OPC_LUI:     info = mk_info(CLS_LUI,     IMM_U,    1'b0, 1'b0, 1'b1);
      OPC_AUIPC:   info = mk_info(CLS_AUIPC,   IMM_U,    1'b0, 1'b0, 1'b1);
      OPC_JAL:     info = mk_info(CLS_JAL,     IMM_J,    1'b0, 1'b0, 1'b1);
      OPC_JALR:    info = mk_info(CLS_JALR,    IMM_I,    1'b1, 1'b0, 1'b1);
      OPC_BRANCH:  info = mk_info(CLS_BRANCH,  IMM_B,    1'b1, 1'b1, 1'b0);
      OPC_LOAD:    info = mk_info(CLS_LOAD,    IMM_I,    1'b1, 1'b0, 1'b1);
      OPC_STORE:   info = mk_info(CLS_STORE,   IMM_S,    1'b1, 1'b1, 1'b0);
      OPC_OPIMM:   info = mk_info(CLS_OPIMM,   IMM_I,    1'b1, 1'b0, 1'b1);
      OPC_OP:      info = mk_info(CLS_OP,      IMM_NONE, 1'b1, 1'b1, 1'b1);
      OPC_SYSTEM:  info = mk_info(CLS_SYSTEM,  IMM_I,    1'b1, 1'b0, 1'b1);
      OPC_MISCMEM: info = mk_info(CLS_MISCMEM, IMM_I,    1'b0, 1'b0, 1'b0);
      default:     info = mk_info(CLS_ILLEGAL, IMM_NONE, 1'b0, 1'b0, 1'b0);
    endcase
    return info;
  endfunction

endpackage

// File: rtl/idu_decode_stage_if.sv
// IFU->IDU->EXU handshake bundle. master = pipeline neighbours, slave = decode stage.
interface idu_decode_stage_if #(
  parameter int XLEN   = 32,
  parameter int NR_REG = 32
);
  import idu_pkg::*;

  localparam int RA_W = $clog2(NR_REG);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  op_class_e       out_class;
  logic [2:0]      out_funct3;
  logic            out_funct7b5;
  logic [RA_W-1:0] out_rs1;
  logic [RA_W-1:0] out_rs2;
  logic [RA_W-1:0] out_rd;
  logic            out_rd_wen;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_class, out_funct3, out_funct7b5,
           out_rs1, out_rs2, out_rd, out_rd_wen, out_imm, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_class, out_funct3, out_funct7b5,
           out_rs1, out_rs2, out_rd, out_rd_wen, out_imm, out_illegal
  );

endinterface

// File: rtl/idu_imm_gen.sv
// Combinational RV32 immediate extractor; the 32-bit immediate is sign-extended to XLEN.
module idu_imm_gen
  import idu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32_s;

  // Assemble the immediate for the selected instruction format.
  always_comb begin
    imm32_s = 32'sd0;
    case (imm_type)
      IMM_I:   imm32_s = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32_s = {inst[31:12], 12'h000};
      IMM_J:   imm32_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32_s = 32'sd0;
    endcase
  end

  assign imm = XLEN'(imm32_s);

endmodule

// File: rtl/idu_decode_stage.sv
// Registered RV32I/RV32E decode stage between IFU and EXU.
// Optional macro IDU_SKID_EN adds a one-entry skid so in_ready is registered.
module idu_decode_stage
  import idu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NR_REG = 32
) (
  input logic               clk,
  input logic               rst,
  idu_decode_stage_if.slave bus
);

  localparam int         RA_W     = $clog2(NR_REG);
  localparam logic [5:0] NR_REG_L = 6'(NR_REG);

  logic            in_ready_s;
  logic            in_fire_s;
  logic            out_fire_s;
  logic            load_s;
  logic [31:0]     src_inst_s;
  logic [XLEN-1:0] src_pc_s;
  op_info_t        info_s;
  bundle_t         bundle_s;
  logic [XLEN-1:0] imm_s;
  logic            range_err_s;

  logic            out_valid_r;
  bundle_t         bundle_r;
  logic [XLEN-1:0] imm_r;
  logic [XLEN-1:0] pc_r;

  assign in_fire_s  = bus.in_valid && in_ready_s;
  assign out_fire_s = out_valid_r && bus.out_ready;

`ifdef IDU_SKID_EN
  logic            skid_valid_r;
  logic [31:0]     skid_inst_r;
  logic [XLEN-1:0] skid_pc_r;

  // The skid is the older instruction, so it wins the decoder whenever it is occupied.
  assign in_ready_s = !skid_valid_r;
  assign src_inst_s = skid_valid_r ? skid_inst_r : bus.in_inst;
  assign src_pc_s   = skid_valid_r ? skid_pc_r : bus.in_pc;
  assign load_s     = (!out_valid_r || bus.out_ready) && (skid_valid_r || in_fire_s);

  // Skid entry: capture on stalled accept, release when promoted into the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_r <= 1'b0;
      skid_inst_r  <= 32'h0000_0000;
      skid_pc_r    <= {XLEN{1'b0}};
    end else if (bus.flush) begin
      skid_valid_r <= 1'b0;
    end else if (skid_valid_r && (!out_valid_r || bus.out_ready)) begin
      skid_valid_r <= 1'b0;
    end else if (in_fire_s && out_valid_r && !bus.out_ready) begin
      skid_valid_r <= 1'b1;
      skid_inst_r  <= bus.in_inst;
      skid_pc_r    <= bus.in_pc;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end
`else
  assign in_ready_s = bus.flush || !out_valid_r || bus.out_ready;
  assign src_inst_s = bus.in_inst;
  assign src_pc_s   = bus.in_pc;
  assign load_s     = in_fire_s;
`endif

  assign info_s = decode_opcode(src_inst_s[6:0]);

  idu_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst     (src_inst_s[31:7]),
    .imm_type (info_s.imm_type),
    .imm      (imm_s)
  );

  // Field extraction plus the RV32E register-range check on the fields this class reads/writes.
  always_comb begin
    range_err_s = (info_s.use_rs1 && ({1'b0, src_inst_s[19:15]} >= NR_REG_L)) ||
                  (info_s.use_rs2 && ({1'b0, src_inst_s[24:20]} >= NR_REG_L)) ||
                  (info_s.use_rd  && ({1'b0, src_inst_s[11:7]}  >= NR_REG_L));
    bundle_s.cls      = info_s.cls;
    bundle_s.funct3   = src_inst_s[14:12];
    bundle_s.funct7b5 = src_inst_s[30];
    bundle_s.rs1      = src_inst_s[19:15];
    bundle_s.rs2      = src_inst_s[24:20];
    bundle_s.rd       = src_inst_s[11:7];
    bundle_s.rd_wen   = info_s.use_rd && (src_inst_s[11:7] != 5'd0) && !range_err_s;
    bundle_s.illegal  = (info_s.cls == CLS_ILLEGAL) || range_err_s;
  end

  // Output pipeline register; flush beats both a pending load and the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      bundle_r    <= BUNDLE_RST;
      imm_r       <= {XLEN{1'b0}};
      pc_r        <= {XLEN{1'b0}};
    end else if (bus.flush) begin
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      bundle_r    <= bundle_s;
      imm_r       <= imm_s;
      pc_r        <= src_pc_s;
    end else if (out_fire_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_pc       = pc_r;
  assign bus.out_class    = bundle_r.cls;
  assign bus.out_funct3   = bundle_r.funct3;
  assign bus.out_funct7b5 = bundle_r.funct7b5;
  assign bus.out_rs1      = bundle_r.rs1[RA_W-1:0];
  assign bus.out_rs2      = bundle_r.rs2[RA_W-1:0];
  assign bus.out_rd       = bundle_r.rd[RA_W-1:0];
  assign bus.out_rd_wen   = bundle_r.rd_wen;
  assign bus.out_imm      = imm_r;
  assign bus.out_illegal  = bundle_r.illegal;

endmodule

// File: doc/idu_decode_stage.md
Name: idu_decode_stage

Overview:
Parametrised successor to the stub decode unit. A registered RV32I/RV32E decode stage between IFU and EXU, with valid/ready handshakes on both sides.
- Extracts rs1/rs2/rd, funct fields, instruction class and a sign-extended immediate into a one-entry pipeline register.
- Supports flush, illegal-instruction detection and a reduced register file (RV32E).

Parameters:
XLEN, 32, datapath/immediate width (32 or 64); immediates sign-extend to XLEN
NR_REG, 32, architectural register count (32 = RV32I, 16 = RV32E)
RA_W, $clog2(NR_REG), register-address width (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  discard held and incoming instruction
in_valid  input  1  IFU presents instruction
in_ready  output  1  IDU can accept
in_inst  input  32  instruction word
in_pc  input  XLEN  instruction PC
out_valid  output  1  decoded bundle valid
out_ready  input  1  EXU accepts bundle
out_pc  output  XLEN  registered PC
out_class  output  4  op class (idu_pkg enum)
out_funct3  output  3  inst[14:12]
out_funct7b5  output  1  inst[30]
out_rs1  output  RA_W  source register 1
out_rs2  output  RA_W  source register 2
out_rd  output  RA_W  destination register
out_rd_wen  output  1  writes rd
out_imm  output  XLEN  sign-extended immediate
out_illegal  output  1  unsupported opcode or register index >= NR_REG

Behaviour:
- Clocking and reset: single clock, posedge; reset is synchronous and active-high.
- Reset values: out_valid=0, all out_* data=0, out_class=CLS_ILLEGAL.
- Handshake:
  - Transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready.
  - in_ready = !out_valid || out_ready (combinational; no skid).
  - Latency 1 cycle: a bundle accepted at edge N is valid from N+1.
  - Full throughput (one per cycle) while out_ready=1.
- Hold: while out_valid && !out_ready, all out_* stay stable.
- Classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM, MISCMEM, ILLEGAL.
  - Any other opcode gives ILLEGAL with out_illegal=1.
- Immediates:
  - I (OPIMM/LOAD/JALR/SYSTEM), S, B (bit0=0), U ({inst[31:12],12'b0}), J (bit0=0).
  - Sign bit is inst[31], extended to XLEN.
  - OP and ILLEGAL: imm=0.
- rd_wen: 1 for LUI/AUIPC/JAL/JALR/LOAD/OPIMM/OP/SYSTEM when rd!=0; otherwise 0.
- Register range (NR_REG=16): any used field with bit 4 set sets illegal=1 and rd_wen=0; fields are truncated to RA_W.
- Illegal bundles still handshake normally; EXU raises the trap.
- flush:
  - Next cycle out_valid=0; any same-cycle input is dropped.
  - in_ready=1 during flush.
  - Flush overrides out_ready.
- Reset mid-transfer: the held bundle is lost; out_valid=0 next cycle.
- Simultaneous out-fire and in-fire: the register loads the new bundle; out_valid stays 1.

Optional Feature:
IDU_SKID_EN
- Defined: adds a one-entry skid buffer so in_ready is a registered signal (in_ready = !skid_valid), breaking the combinational out_ready->in_ready path.
  - An input arriving while the output is stalled goes to the skid and is promoted when out fires.
  - Order is preserved; flush clears both entries.
- Undefined: single register; in_ready is combinational as above.

Decomposition:
- idu_pkg holds:
  - opcode localparams (7'b0110111 etc.)
  - op-class enum (4-bit)
  - immediate-type enum
  - the decoded-bundle struct typedef
- One combinational sub-module, idu_imm_gen (inst, imm type -> XLEN immediate), is reused by the skid path.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1: next cycle out_class=OPIMM, rd=1, rs1=0, imm=5, rd_wen=1, illegal=0.
- beq x0,x0,-4 (0xFE000EE3): out_class=BRANCH, imm=0xFFFFFFFC, rd_wen=0; lui x5,0x12345 (0x123452B7): imm=0x12345000.
- Back-to-back stream, out_ready=0 for 3 cycles then 1: first bundle held stable, second accepted only after release, no loss or duplication.
  - Repeat with IDU_SKID_EN: second enters the skid, in_ready=0 the cycle after.
- NR_REG=16, add x17,x0,x0 (0x000008B3): illegal=1, rd_wen=0; same instruction with NR_REG=32: legal, rd=17.
- flush asserted with out_valid=1 and in_valid=1 together: out_valid=0 next cycle, the new instruction is never presented.
- rst asserted mid-stall: out_valid=0 after the edge; first post-reset instruction decodes correctly; opcode 0x7F gives CLS_ILLEGAL.
